// File: rtl/cr_sa_agg_pkg.sv
// Shared control record and default sizing for the statistics aggregation core.
// Control fields use fixed maximum widths so one record type serves every parametrisation.
package cr_sa_aggPKG;

    localparam int DEF_NUM_COUNTERS = 64;
    localparam int DEF_NUM_GROUPS   = 16;
    localparam int DEF_GROUP_WIDTH  = 64;
    localparam int DEF_COUNT_WIDTH  = 50;

    // Upper bounds on selector and counter width carried by the control record.
    localparam int SEL_MAX_W = 32;
    localparam int CNT_MAX_W = 64;

    typedef struct packed {
        logic [SEL_MAX_W-1:0] sel;
        logic                 en;
        logic                 sat;
        logic                 clr_on_snap;
        logic [CNT_MAX_W-1:0] thresh;
    } sa_agg_ctrl_t;

endpackage

// File: rtl/cr_sa_agg_if.sv
// Stat-event, request, control and result bundle between the engine/register side and the core.
interface cr_sa_agg_if
    import cr_sa_aggPKG::*;
#(
    parameter int NUM_COUNTERS = DEF_NUM_COUNTERS,
    parameter int NUM_GROUPS   = DEF_NUM_GROUPS,
    parameter int GROUP_WIDTH  = DEF_GROUP_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
);
    localparam int EV_W  = NUM_GROUPS * GROUP_WIDTH;
    localparam int SEL_W = $clog2(EV_W);

    logic [EV_W-1:0]                     stat_events;
    logic                                snap_req;
    logic                                clear_req;
    logic [NUM_COUNTERS*SEL_W-1:0]       ctrl_sel;
    logic [NUM_COUNTERS-1:0]             ctrl_en;
    logic [NUM_COUNTERS-1:0]             ctrl_sat;
    logic [NUM_COUNTERS-1:0]             ctrl_clr_on_snap;
    logic [NUM_COUNTERS*COUNT_WIDTH-1:0] ctrl_thresh;
    logic [NUM_COUNTERS*COUNT_WIDTH-1:0] sa_count;
    logic [NUM_COUNTERS*COUNT_WIDTH-1:0] sa_snapshot;
    logic [NUM_COUNTERS-1:0]             sa_wrap;
    logic [NUM_COUNTERS-1:0]             sa_thr_irq;
    logic                                snap_done;

    modport master (
        output stat_events, snap_req, clear_req,
        output ctrl_sel, ctrl_en, ctrl_sat, ctrl_clr_on_snap, ctrl_thresh,
        input  sa_count, sa_snapshot, sa_wrap, sa_thr_irq, snap_done
    );

    modport slave (
        input  stat_events, snap_req, clear_req,
        input  ctrl_sel, ctrl_en, ctrl_sat, ctrl_clr_on_snap, ctrl_thresh,
        output sa_count, sa_snapshot, sa_wrap, sa_thr_irq, snap_done
    );

endinterface

// File: rtl/cr_sa_agg_counter.sv
// One programmable event counter: select, increment with saturate/wrap, snapshot,
// clear and the sticky wrap/threshold flags.
module cr_sa_agg_counter
    import cr_sa_aggPKG::*;
#(
    parameter int EV_W        = 1024,
    parameter int SEL_W       = 10,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EV_W-1:0]        ev,
    input  sa_agg_ctrl_t           ctrl,
    input  logic                   snap_p,
    input  logic                   clr_p,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] snapshot,
    output logic                   wrap,
    output logic                   thr_irq
);

    logic                   hit;
    logic                   wrap_evt;
    logic                   thr_hit;
    logic [COUNT_WIDTH-1:0] inc_val;
    logic [COUNT_WIDTH-1:0] nxt;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hit      = 1'b0;
        wrap_evt = 1'b0;
        inc_val  = count + COUNT_WIDTH'(1);

        if (ctrl.sel < SEL_MAX_W'(EV_W)) begin
            hit = ctrl.en & ev[ctrl.sel[SEL_W-1:0]];
        end

        if (&count) begin
            if (ctrl.sat) begin
                inc_val = count;
            end else begin
                inc_val  = '0;
                wrap_evt = hit;
            end
        end

        nxt     = hit ? inc_val : count;
        thr_hit = (ctrl.thresh != '0) && (CNT_MAX_W'(nxt) >= ctrl.thresh);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            snapshot <= '0;
            wrap     <= 1'b0;
            thr_irq  <= 1'b0;
        end else begin
            if (snap_p) begin
                snapshot <= nxt;
            end
            // A clear overrides counting and flag setting, even alongside a snapshot.
            if (clr_p) begin
                count   <= '0;
                wrap    <= 1'b0;
                thr_irq <= 1'b0;
            end else begin
                count <= (snap_p && ctrl.clr_on_snap) ? '0 : nxt;
                if (wrap_evt) wrap    <= 1'b1;
                if (thr_hit)  thr_irq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_sa_agg_core.sv
// Statistics aggregation core: registers the event vector, edge-detects snapshot/clear
// requests and drives NUM_COUNTERS programmable counters.
module cr_sa_agg_core
    import cr_sa_aggPKG::*;
#(
    parameter int NUM_COUNTERS = DEF_NUM_COUNTERS,
    parameter int NUM_GROUPS   = DEF_NUM_GROUPS,
    parameter int GROUP_WIDTH  = DEF_GROUP_WIDTH,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
    localparam int EV_W        = NUM_GROUPS * GROUP_WIDTH,
    localparam int SEL_W       = $clog2(EV_W)
) (
    input logic         clk,
    input logic         rst_n,
    cr_sa_agg_if.slave  bus
);

    logic [EV_W-1:0]         ev_r;
    logic                    snap_req_r;
    logic                    clear_req_r;
    logic                    snap_p;
    logic                    clr_p;
    logic                    snap_done_r;
    logic [NUM_COUNTERS-1:0] wrap_v;
    logic [NUM_COUNTERS-1:0] thr_v;

    // Request history resets low so a level still high at reset release counts as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_r        <= '0;
            snap_req_r  <= 1'b0;
            clear_req_r <= 1'b0;
            snap_p      <= 1'b0;
            clr_p       <= 1'b0;
            snap_done_r <= 1'b0;
        end else begin
            ev_r        <= bus.stat_events;
            snap_req_r  <= bus.snap_req;
            clear_req_r <= bus.clear_req;
            snap_p      <= bus.snap_req & ~snap_req_r;
            clr_p       <= bus.clear_req & ~clear_req_r;
            snap_done_r <= snap_p;
        end
    end

    assign bus.snap_done  = snap_done_r;
    assign bus.sa_wrap    = wrap_v;
    assign bus.sa_thr_irq = thr_v;

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        sa_agg_ctrl_t           ctrl;
        logic [COUNT_WIDTH-1:0] count_i;
        logic [COUNT_WIDTH-1:0] snapshot_i;

        always_comb begin
            ctrl             = '0;
            ctrl.sel         = SEL_MAX_W'(bus.ctrl_sel[i*SEL_W +: SEL_W]);
            ctrl.en          = bus.ctrl_en[i];
            ctrl.sat         = bus.ctrl_sat[i];
            ctrl.clr_on_snap = bus.ctrl_clr_on_snap[i];
            ctrl.thresh      = CNT_MAX_W'(bus.ctrl_thresh[i*COUNT_WIDTH +: COUNT_WIDTH]);
        end

        cr_sa_agg_counter #(
            .EV_W        (EV_W),
            .SEL_W       (SEL_W),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_counter (
            .clk      (clk),
            .rst_n    (rst_n),
            .ev       (ev_r),
            .ctrl     (ctrl),
            .snap_p   (snap_p),
            .clr_p    (clr_p),
            .count    (count_i),
            .snapshot (snapshot_i),
            .wrap     (wrap_v[i]),
            .thr_irq  (thr_v[i])
        );

        assign bus.sa_count[i*COUNT_WIDTH +: COUNT_WIDTH]    = count_i;
        assign bus.sa_snapshot[i*COUNT_WIDTH +: COUNT_WIDTH] = snapshot_i;
    end

endmodule
